// File: rtl/kgp_pkg.sv
// Shared KGPminiRISC encodings: opcodes, ALU codes, control-field values
// and the packed control bundle passed from decoder to output register.
package kgp_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_COMP = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_XOR  = 6'd3;
  localparam logic [5:0] OP_SHLL = 6'd4;
  localparam logic [5:0] OP_SHRL = 6'd5;
  localparam logic [5:0] OP_SHRA = 6'd6;
  localparam logic [5:0] OP_ADDI = 6'd7;
  localparam logic [5:0] OP_LW   = 6'd8;
  localparam logic [5:0] OP_SW   = 6'd9;
  localparam logic [5:0] OP_B    = 6'd10;
  localparam logic [5:0] OP_BL   = 6'd11;
  localparam logic [5:0] OP_BR   = 6'd12;
  localparam logic [5:0] OP_BLTZ = 6'd13;
  localparam logic [5:0] OP_BZ   = 6'd14;
  localparam logic [5:0] OP_BNZ  = 6'd15;
  localparam logic [5:0] OP_BCY  = 6'd16;
  localparam logic [5:0] OP_BNCY = 6'd17;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_COMP = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SHLL = 3'b100;
  localparam logic [2:0] ALU_SHRL = 3'b101;
  localparam logic [2:0] ALU_SHRA = 3'b110;

  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_IMM = 1'b1;

  localparam logic [1:0] DST_RS   = 2'b00;
  localparam logic [1:0] DST_RT   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] CJ_NONE  = 3'b000;
  localparam logic [2:0] CJ_LTZ   = 3'b001;
  localparam logic [2:0] CJ_ZERO  = 3'b010;
  localparam logic [2:0] CJ_NZERO = 3'b011;
  localparam logic [2:0] CJ_CARRY = 3'b100;
  localparam logic [2:0] CJ_NCY   = 3'b101;

  localparam logic [1:0] AS_NONE  = 2'b00;
  localparam logic [1:0] AS_LABEL = 2'b01;
  localparam logic [1:0] AS_REG   = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_op;
    logic [2:0] cond_jump;
    logic       uncond_jump;
    logic [1:0] addr_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/cntrl_decode.sv
// Combinational opcode decoder; unknown opcodes decode to an all-zero NOP.
module cntrl_decode
  import kgp_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_ADD: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_REG, ALU_ADD};  end
      OP_COMP: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_REG, ALU_COMP}; end
      OP_AND: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_REG, ALU_AND};  end
      OP_XOR: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_REG, ALU_XOR};  end
      OP_SHLL: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_REG, ALU_SHLL}; end
      OP_SHRL: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_REG, ALU_SHRL}; end
      OP_SHRA: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_REG, ALU_SHRA}; end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_op = {ALU_SRC_IMM, ALU_ADD};  end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = WB_MEM;
        ctrl.alu_op     = {ALU_SRC_IMM, ALU_ADD};
      end
      OP_SW: begin ctrl.mem_write = 1'b1; ctrl.alu_op = {ALU_SRC_IMM, ALU_ADD}; end
      OP_B: begin ctrl.uncond_jump = 1'b1; ctrl.addr_sel = AS_LABEL; end
      OP_BL: begin
        ctrl.reg_write   = 1'b1;
        ctrl.reg_dst     = DST_LINK;
        ctrl.mem_to_reg  = WB_PC4;
        ctrl.uncond_jump = 1'b1;
        ctrl.addr_sel    = AS_LABEL;
      end
      OP_BR: begin ctrl.uncond_jump = 1'b1; ctrl.addr_sel = AS_REG; end
      OP_BLTZ: begin ctrl.cond_jump = CJ_LTZ;   ctrl.addr_sel = AS_LABEL; end
      OP_BZ: begin ctrl.cond_jump = CJ_ZERO;  ctrl.addr_sel = AS_LABEL; end
      OP_BNZ: begin ctrl.cond_jump = CJ_NZERO; ctrl.addr_sel = AS_LABEL; end
      OP_BCY: begin ctrl.cond_jump = CJ_CARRY; ctrl.addr_sel = AS_LABEL; end
      OP_BNCY: begin ctrl.cond_jump = CJ_NCY;   ctrl.addr_sel = AS_LABEL; end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/cntrl_unit.sv
// KGPminiRISC main control unit: decoded strobes registered one clock after
// the opcode, cleared to NOP by synchronous reset.
module cntrl_unit
  import kgp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] MemToReg,
  output logic [3:0] ALUop,
  output logic [2:0] CondJump,
  output logic       UncondJump,
  output logic [1:0] AddrSel
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  cntrl_decode u_decode (
    .opcode (opcode),
    .ctrl   (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= CTRL_NOP;
    else     ctrl_q <= ctrl_d;
  end

  assign RegWrite   = ctrl_q.reg_write;
  assign RegDst     = ctrl_q.reg_dst;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign ALUop      = ctrl_q.alu_op;
  assign CondJump   = ctrl_q.cond_jump;
  assign UncondJump = ctrl_q.uncond_jump;
  assign AddrSel    = ctrl_q.addr_sel;

endmodule

// File: tb/tb_cntrl_unit.sv
// Bench for cntrl_unit: directed reset/sweep/illegal cases plus random opcodes
// checked against an arithmetic reference of the decode table.
module tb_cntrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       RegWrite, MemRead, MemWrite, UncondJump;
  logic [1:0] RegDst, MemToReg, AddrSel;
  logic [3:0] ALUop;
  logic [2:0] CondJump;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [16:0] exp_q;
  logic        exp_valid = 1'b0;

  cntrl_unit dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .ALUop      (ALUop),
    .CondJump   (CondJump),
    .UncondJump (UncondJump),
    .AddrSel    (AddrSel)
  );

  always #5 clk = ~clk;

  // Reference decode, field order {rw, dst, mr, mw, wb, alu, cj, uj, as}
  function automatic logic [16:0] ref_ctrl(input int unsigned op);
    logic rw, mr, mw, uj;
    logic [1:0] dst, wb, as_;
    logic [3:0] alu;
    logic [2:0] cj;
    rw = 0; mr = 0; mw = 0; uj = 0; dst = 0; wb = 0; as_ = 0; alu = 0; cj = 0;
    if (op <= 6) begin
      rw = 1; alu = 4'(op);
    end else if (op == 7) begin
      rw = 1; alu = 4'd8;
    end else if (op == 8) begin
      rw = 1; dst = 2'd1; mr = 1; wb = 2'd1; alu = 4'd8;
    end else if (op == 9) begin
      mw = 1; alu = 4'd8;
    end else if (op == 10) begin
      uj = 1; as_ = 2'd1;
    end else if (op == 11) begin
      rw = 1; dst = 2'd2; wb = 2'd2; uj = 1; as_ = 2'd1;
    end else if (op == 12) begin
      uj = 1; as_ = 2'd2;
    end else if (op <= 17) begin
      cj = 3'(op - 12); as_ = 2'd1;
    end
    return {rw, dst, mr, mw, wb, alu, cj, uj, as_};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {RegWrite, RegDst, MemRead, MemWrite, MemToReg, ALUop, CondJump, UncondJump, AddrSel};
  endfunction

  // Check what the previous edge should have produced, then drive new inputs.
  task automatic step(input logic rst_v, input logic [5:0] op_v, input string tag);
    @(negedge clk);
    if (exp_valid) begin
      check_eq(tag, 32'(outs()), 32'(exp_q));
      check_eq({tag, "_inv_mem"}, 32'(MemRead & MemWrite), 32'd0);
      check_eq({tag, "_inv_jmp"}, 32'((CondJump != 3'd0) & UncondJump), 32'd0);
      check_eq({tag, "_inv_wb"}, 32'(!RegWrite && (RegDst != 2'd0 || MemToReg != 2'd0)), 32'd0);
    end
    rst    = rst_v;
    opcode = op_v;
    exp_q  = rst_v ? 17'd0 : ref_ctrl(int'(op_v));
    exp_valid = 1'b1;
  endtask

  initial begin
    // Reset held two cycles with LW present, then release.
    step(1'b1, 6'd8, "rst_a");
    step(1'b1, 6'd8, "rst_b");
    step(1'b0, 6'd8, "rst_hold");
    step(1'b0, 6'd0, "rel_lw");

    for (int unsigned op = 0; op < 18; op++)
      step(1'b0, 6'(op), $sformatf("sweep_op%0d", op));

    step(1'b0, 6'd18, "sweep_tail");
    step(1'b0, 6'd31, "illegal18");
    step(1'b0, 6'd63, "illegal31");

    // Mid-stream reset while LW is presented.
    step(1'b0, 6'd8, "illegal63");
    step(1'b1, 6'd8, "mid_lw");
    step(1'b0, 6'd8, "mid_rst");
    step(1'b0, 6'd11, "mid_lw_back");
    step(1'b0, 6'd16, "bl");
    step(1'b0, 6'd12, "bcy");
    step(1'b0, 6'd9, "br");

    for (int unsigned i = 0; i < 1000; i++) begin
      logic r;
      logic [5:0] op;
      r  = ($urandom_range(0, 49) == 0);
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 17));
      step(r, op, $sformatf("rand%0d", i));
    end
    step(1'b0, 6'd0, "rand_last");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cntrl_unit.md
# cntrl_unit

Main control decoder for the KGPminiRISC single-issue datapath. It takes the 6-bit primary opcode of the current instruction and produces every datapath control strobe:
- register-file write enable and destination select
- data-memory read/write
- write-back source
- ALU operation and operand source
- branch/jump controls

The outputs are registered, so the decoded controls for an opcode are presented one clock after it.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high; one clock only.
- opcode  input  6  instruction opcode; values 0–17 defined, 18–63 illegal.
- RegWrite  output  1  register-file write enable.
- RegDst  output  2  destination register: 00 = rs field, 01 = rt field, 10 = link register r31, 11 unused.
- MemRead  output  1  data-memory read enable.
- MemWrite  output  1  data-memory write enable.
- MemToReg  output  2  write-back source: 00 = ALU result, 01 = memory data, 10 = PC+4, 11 unused.
- ALUop  output  4  bit 3 selects the B operand (0 = register, 1 = sign-extended immediate).
  - Bits 2:0 select the operation: 000 add, 001 two's complement, 010 and, 011 xor, 100 shift-left-logical, 101 shift-right-logical, 110 shift-right-arithmetic, 111 reserved.
- CondJump  output  3  branch condition: 000 none, 001 lt-zero, 010 zero, 011 non-zero, 100 carry, 101 no-carry, 110/111 unused.
- UncondJump  output  1  unconditional jump.
- AddrSel  output  2  branch target source: 00 none, 01 PC-relative label, 10 register rs, 11 unused.

## Operation
The decode table is listed per opcode. Any output not named for an opcode is 0.
- 0 ADD: RegWrite=1, ALUop=0000.
- 1 COMP: RegWrite=1, ALUop=0001.
- 2 AND: RegWrite=1, ALUop=0010.
- 3 XOR: RegWrite=1, ALUop=0011.
- 4 SHLL: RegWrite=1, ALUop=0100.
- 5 SHRL: RegWrite=1, ALUop=0101.
- 6 SHRA: RegWrite=1, ALUop=0110.
- 7 ADDI: RegWrite=1, ALUop=1000.
- 8 LW: RegWrite=1, RegDst=01, MemRead=1, MemToReg=01, ALUop=1000.
- 9 SW: MemWrite=1, ALUop=1000.
- 10 B: UncondJump=1, AddrSel=01.
- 11 BL: RegWrite=1, RegDst=10, MemToReg=10, UncondJump=1, AddrSel=01.
- 12 BR: UncondJump=1, AddrSel=10.
- 13 BLTZ: CondJump=001, AddrSel=01.
- 14 BZ: CondJump=010, AddrSel=01.
- 15 BNZ: CondJump=011, AddrSel=01.
- 16 BCY: CondJump=100, AddrSel=01.
- 17 BNCY: CondJump=101, AddrSel=01.
- 18–63: NOP, all outputs 0. No illegal-instruction flag.

Invariants:
- MemRead and MemWrite are never both 1.
- CondJump ≠ 000 implies UncondJump=0.
- RegWrite=0 implies RegDst=00 and MemToReg=00.

## Timing
- Each output register loads the decode of the opcode sampled at a rising clk edge. Latency is 1 cycle.
- rst=1 at a rising edge clears every output to 0, giving a NOP state. rst has priority over opcode.
- When rst is released, the first valid output appears one edge after the first non-reset edge.
- rst asserted mid-stream clears outputs at the next edge. Decoding resumes normally once rst falls.
- An opcode change between edges has no effect until the next edge. There are no handshakes.

## Structure
- Shared package kgp_pkg holds:
  - Opcode localparams OP_ADD … OP_BNCY.
  - ALU operation codes and the operand-source bit.
  - RegDst, MemToReg, CondJump and AddrSel encodings.
- The combinational decoder is a separate sub-module, cntrl_decode. It is a pure case on opcode with a default-NOP arm.
- cntrl_unit wraps cntrl_decode with the synchronous-reset output register.

## Test plan
- Reset: hold rst=1 for 2 cycles with opcode=8 → all outputs stay 0. Release rst → LW controls appear one edge later.
- Full sweep: apply opcodes 0–17, one per cycle → each output matches its table row one cycle after it is applied. Examples: opcode 7 → ALUop=1000, RegWrite=1; opcode 9 → MemWrite=1, RegWrite=0.
- Link and branch types:
  - opcode 11 → RegDst=10, MemToReg=10, UncondJump=1, AddrSel=01.
  - opcode 12 → AddrSel=10.
  - opcode 16 → CondJump=100, UncondJump=0.
- Illegal opcodes: apply 18, 31 and 63 → every output is 0 one cycle later.
- Mid-stream reset: drive opcode 8, then assert rst for one cycle while opcode=8 → outputs are 0 for that cycle and return to LW values the cycle after rst drops.
- Invariant check: run random opcodes for 1000 cycles → the three invariants in Operation are never violated.
